imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares the core's single memory port between the fetch stage (instruction requests) and the execute/mem stage (data loads/stores).
- One outstanding transaction at a time.
- Data side has priority; a starvation counter guarantees fetch forward progress.
- Sits between fetch/exec stages and the memory controller, replacing the fetch stage's direct always-strobe memory hookup.

Parameters:
STARVE_MAX, 4, consecutive cycles a pending fetch may lose arbitration before it is forced to win (1..15)
TIMEOUT, 64, cycles waiting for mem_rsp_valid before abandoning the transaction (>=2)

Ports:
i_clk  input  1  clock
i_reset_n  input  1  synchronous active-low reset
if_req_stb  input  1  fetch request
if_req_addr  input  32  fetch address
if_req_ready  output  1  fetch request accepted this cycle
if_rsp_valid  output  1  fetch response valid (1-cycle pulse)
if_rsp_data  output  32  fetch instruction word
d_req_stb  input  1  data request
d_req_we  input  1  1=store, 0=load
d_req_addr  input  32  data address
d_req_wdata  input  32  store data
d_req_ready  output  1  data request accepted this cycle
d_rsp_valid  output  1  data response/ack valid (1-cycle pulse)
d_rsp_data  output  32  load data
mem_req_stb  output  1  request to memory
mem_req_we  output  1  write enable to memory
mem_req_addr  output  32  address to memory
mem_req_wdata  output  32  write data to memory
mem_rsp_valid  input  1  memory response/ack (loads and stores)
mem_rsp_data  input  32  memory read data
err_flags  output  2  sticky: [0] stray response, [1] timeout
perf_conflicts  output  32  cycles both requesters pending (optional feature)

Behaviour:
- States: IDLE, WAIT_IF, WAIT_D.
- Issue window: state==IDLE, or state is WAIT_* with mem_rsp_valid=1 this cycle (back-to-back issue).
- Grant in issue window: d wins if d_req_stb, unless starve_cnt==STARVE_MAX and if_req_stb, then if wins. if wins when only if_req_stb.
- mem_req_* driven combinationally from the granted requester; mem_req_stb=0 and mem_req_we=0 when no grant.
- *_req_ready asserted combinationally only to the granted side; a request is accepted iff stb&ready.
- On grant: state<=WAIT_IF or WAIT_D; timeout counter cleared.
- starve_cnt (4 bits):
  - cleared when fetch is granted or if_req_stb=0.
  - increments (saturating at STARVE_MAX) each issue-window cycle where if_req_stb=1 and d wins.
  - holds outside issue windows.
- Response routing: mem_rsp_valid in WAIT_IF -> if_rsp_valid=1 next cycle, if_rsp_data<=mem_rsp_data (registered, 1-cycle latency); likewise WAIT_D -> d_rsp_*. Store acks also pulse d_rsp_valid; d_rsp_data then equals mem_rsp_data (don't-care to consumer).
- With no new grant in the response cycle, state<=IDLE.
- mem_rsp_valid in IDLE: ignored, err_flags[0]<=1.
- Timeout: in WAIT_* with no mem_rsp_valid for TIMEOUT cycles -> state<=IDLE, err_flags[1]<=1, no rsp pulse to requester. A late response then sets err_flags[0].
- Reset (i_reset_n=0 at clock edge), including mid-transaction:
  - state=IDLE; starve_cnt=0; timeout counter=0; err_flags=0; perf_conflicts=0.
  - if_rsp_valid=d_rsp_valid=0; rsp data=32'h0.
  - Outstanding transaction dropped; no response delivered.
  - While reset is asserted, no grants: all ready=0, mem_req_stb=0.
- Rsp valid outputs are 1-cycle pulses; data regs hold their last value otherwise.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: perf_conflicts increments by 1 each cycle with i_reset_n=1, if_req_stb=1 and d_req_stb=1; wraps at 2^32.
- Undefined: counter logic not built; perf_conflicts tied to 32'h0. Port present in both builds.

Test Plan:
- Fetch only: if_req_stb=1, addr 0x100; mem acks 1 cycle later with 0xDEADBEEF -> mem_req_addr=0x100, if_req_ready=1 in issue cycle, if_rsp_valid pulses with 0xDEADBEEF the cycle after the ack; next fetch issues in the ack cycle.
- Contention: if and d held continuously, memory acks every cycle, STARVE_MAX=4 -> grants d,d,d,d,if repeating; d_rsp count 4 per if_rsp; perf_conflicts increments every cycle (feature on), stays 0 (feature off).
- Store: d_req_we=1, addr 0x2000, wdata 0x12345678 -> mem_req_we=1, mem_req_wdata=0x12345678; d_rsp_valid pulses once after ack; if_rsp_valid stays 0.
- Timeout: grant d, withhold mem_rsp_valid 64 cycles -> state returns to IDLE, err_flags=2'b10, no d_rsp_valid; a late ack then sets err_flags=2'b11.
- Reset mid-op: assert i_reset_n=0 in WAIT_IF, then ack arrives after release -> no if_rsp_valid, err_flags[0]=1, starve_cnt=0.
- Stray ack in IDLE after reset -> all rsp outputs 0, err_flags=2'b01, mem_req_stb=0 throughout reset.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between fetch and data stages: data has priority, a starvation
// counter forces fetch through. Build with ARB_PERF_CNT_EN to enable perf_conflicts.
module imem_dmem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        if_req_stb,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_req_stb,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        mem_req_stb,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [1:0]  err_flags,
    output logic [31:0] perf_conflicts
);

    localparam int unsigned TmoW = $clog2(TIMEOUT);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitIf,
        StWaitD
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [1:0]      err_q, err_d;
    logic            if_rsp_valid_q, if_rsp_valid_d;
    logic            d_rsp_valid_q, d_rsp_valid_d;
    logic [31:0]     if_rsp_data_q, if_rsp_data_d;
    logic [31:0]     d_rsp_data_q, d_rsp_data_d;

    logic issue_win;
    logic starve_hit;
    logic grant_if;
    logic grant_d;

    // A response cycle doubles as an issue slot so back-to-back traffic keeps the port busy.
    always_comb begin
        issue_win  = i_reset_n && ((state_q == StIdle) || mem_rsp_valid);
        starve_hit = (starve_q == StarveMax) && if_req_stb;
        grant_d    = issue_win && d_req_stb && !starve_hit;
        grant_if   = issue_win && if_req_stb && !grant_d;
    end

    always_comb begin
        if_req_ready  = grant_if;
        d_req_ready   = grant_d;
        mem_req_stb   = grant_if || grant_d;
        mem_req_we    = 1'b0;
        mem_req_addr  = 32'h0;
        mem_req_wdata = 32'h0;
        if (grant_d) begin
            mem_req_we    = d_req_we;
            mem_req_addr  = d_req_addr;
            mem_req_wdata = d_req_wdata;
        end else if (grant_if) begin
            mem_req_addr  = if_req_addr;
        end
    end

    always_comb begin
        state_d        = state_q;
        tmo_d          = tmo_q;
        err_d          = err_q;
        if_rsp_valid_d = 1'b0;
        d_rsp_valid_d  = 1'b0;
        if_rsp_data_d  = if_rsp_data_q;
        d_rsp_data_d   = d_rsp_data_q;

        unique case (state_q)
            StIdle: begin
                if (mem_rsp_valid) begin
                    err_d[0] = 1'b1;
                end
            end
            StWaitIf: begin
                if (mem_rsp_valid) begin
                    if_rsp_valid_d = 1'b1;
                    if_rsp_data_d  = mem_rsp_data;
                    state_d        = StIdle;
                end else if (tmo_q == TmoLast) begin
                    state_d  = StIdle;
                    err_d[1] = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StWaitD: begin
                if (mem_rsp_valid) begin
                    d_rsp_valid_d = 1'b1;
                    d_rsp_data_d  = mem_rsp_data;
                    state_d       = StIdle;
                end else if (tmo_q == TmoLast) begin
                    state_d  = StIdle;
                    err_d[1] = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A grant in the response cycle overrides the return to idle.
        if (grant_if) begin
            state_d = StWaitIf;
            tmo_d   = '0;
        end else if (grant_d) begin
            state_d = StWaitD;
            tmo_d   = '0;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req_stb || grant_if) begin
            starve_d = 4'd0;
        end else if (grant_d && (starve_q != StarveMax)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q        <= StIdle;
            starve_q       <= 4'd0;
            tmo_q          <= '0;
            err_q          <= 2'b00;
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            if_rsp_data_q  <= 32'h0;
            d_rsp_data_q   <= 32'h0;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            tmo_q          <= tmo_d;
            err_q          <= err_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            d_rsp_valid_q  <= d_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            d_rsp_data_q   <= d_rsp_data_d;
        end
    end

    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign d_rsp_valid  = d_rsp_valid_q;
    assign d_rsp_data   = d_rsp_data_q;
    assign err_flags    = err_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            perf_q <= 32'h0;
        end else if (if_req_stb && d_req_stb) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_conflicts = perf_q;
`else
    assign perf_conflicts = 32'h0;
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: stimulus pushes expected responses, a negedge
// monitor pops and checks data and arrival cycle.
module tb_imem_dmem_arbiter;

    logic        i_clk;
    logic        i_reset_n;
    logic        if_req_stb;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_stb;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        mem_req_stb;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [1:0]  err_flags;
    logic [31:0] perf_conflicts;

    imem_dmem_arbiter #(
        .STARVE_MAX(4),
        .TIMEOUT   (64)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .if_req_stb    (if_req_stb),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .d_req_stb     (d_req_stb),
        .d_req_we      (d_req_we),
        .d_req_addr    (d_req_addr),
        .d_req_wdata   (d_req_wdata),
        .d_req_ready   (d_req_ready),
        .d_rsp_valid   (d_rsp_valid),
        .d_rsp_data    (d_rsp_data),
        .mem_req_stb   (mem_req_stb),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .err_flags     (err_flags),
        .perf_conflicts(perf_conflicts)
    );

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t if_q[$];
    exp_t d_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   if_pulses = 0;
    int   d_pulses = 0;
    bit   prev_if;
    bit   exp_if;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation, including its cycle.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (if_rsp_valid === 1'b1) begin
            if_pulses++;
            if (if_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL if_rsp_unexpected: got pulse data 0x%08h, expected none", if_rsp_data);
            end else begin
                e = if_q.pop_front();
                check("if_rsp_data", if_rsp_data, e.data);
                check("if_rsp_cycle", cyc, e.at);
            end
        end
        if (d_rsp_valid === 1'b1) begin
            d_pulses++;
            if (d_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL d_rsp_unexpected: got pulse data 0x%08h, expected none", d_rsp_data);
            end else begin
                e = d_q.pop_front();
                check("d_rsp_data", d_rsp_data, e.data);
                check("d_rsp_cycle", cyc, e.at);
            end
        end
    end

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        @(negedge i_clk);
    endtask

    task automatic idle_inputs();
        if_req_stb    = 1'b0;
        d_req_stb     = 1'b0;
        d_req_we      = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic ack(input bit to_if, input logic [31:0] data);
        exp_t e;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        e.data = data;
        e.at   = cyc + 1;
        if (to_if) if_q.push_back(e);
        else d_q.push_back(e);
    endtask

    task automatic stray_ack(input logic [31:0] data);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
    endtask

    task automatic pulse_reset();
        next_cycle();
        i_reset_n = 1'b0;
        idle_inputs();
        next_cycle();
        i_reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish within time bound");
        $fatal(1);
    end

    initial begin : stimulus
        i_reset_n     = 1'b0;
        if_req_stb    = 1'b1;
        d_req_stb     = 1'b1;
        d_req_we      = 1'b0;
        if_req_addr   = 32'h0000_0040;
        d_req_addr    = 32'h0000_0080;
        d_req_wdata   = 32'h0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;

        // Reset with both requesters pending: no grants, all outputs cleared.
        repeat (3) begin
            next_cycle();
            settle();
            check("rst_mem_req_stb", mem_req_stb, 0);
            check("rst_if_ready", if_req_ready, 0);
            check("rst_d_ready", d_req_ready, 0);
        end
        check("rst_if_rsp_valid", if_rsp_valid, 0);
        check("rst_d_rsp_valid", d_rsp_valid, 0);
        check("rst_if_rsp_data", if_rsp_data, 32'h0);
        check("rst_d_rsp_data", d_rsp_data, 32'h0);
        check("rst_err", err_flags, 2'b00);
        check("rst_perf", perf_conflicts, 32'h0);

        // Fetch only, with the next fetch issued in the ack cycle.
        next_cycle();
        i_reset_n = 1'b1;
        idle_inputs();
        if_req_stb  = 1'b1;
        if_req_addr = 32'h0000_0100;
        settle();
        check("fetch_mem_stb", mem_req_stb, 1);
        check("fetch_mem_addr", mem_req_addr, 32'h0000_0100);
        check("fetch_mem_we", mem_req_we, 0);
        check("fetch_if_ready", if_req_ready, 1);
        check("fetch_d_ready", d_req_ready, 0);
        next_cycle();
        if_req_addr = 32'h0000_0104;
        ack(1'b1, 32'hDEAD_BEEF);
        settle();
        check("fetch_b2b_ready", if_req_ready, 1);
        check("fetch_b2b_addr", mem_req_addr, 32'h0000_0104);
        next_cycle();
        if_req_stb = 1'b0;
        ack(1'b1, 32'h0000_0013);
        settle();
        check("fetch_no_grant", mem_req_stb, 0);
        next_cycle();
        idle_inputs();
        settle();

        // Store: write data presented, one d_rsp pulse, no fetch pulse.
        next_cycle();
        d_req_stb   = 1'b1;
        d_req_we    = 1'b1;
        d_req_addr  = 32'h0000_2000;
        d_req_wdata = 32'h1234_5678;
        settle();
        check("store_mem_we", mem_req_we, 1);
        check("store_mem_wdata", mem_req_wdata, 32'h1234_5678);
        check("store_mem_addr", mem_req_addr, 32'h0000_2000);
        check("store_d_ready", d_req_ready, 1);
        check("store_if_ready", if_req_ready, 0);
        next_cycle();
        d_req_stb = 1'b0;
        d_req_we  = 1'b0;
        ack(1'b0, 32'h0000_0055);
        settle();
        check("store_idle_we", mem_req_we, 0);
        next_cycle();
        idle_inputs();
        settle();
        next_cycle();
        settle();
        check("store_drained_d", d_q.size(), 0);
        check("store_drained_if", if_q.size(), 0);

        // Contention: grants d,d,d,d,if repeating while memory acks every cycle.
        pulse_reset();
        if_pulses = 0;
        d_pulses  = 0;
        prev_if   = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k != 0) next_cycle();
            if_req_stb  = 1'b1;
            d_req_stb   = 1'b1;
            d_req_we    = 1'b0;
            if_req_addr = 32'h0000_1000 + 32'(4 * k);
            d_req_addr  = 32'h0000_3000 + 32'(4 * k);
            if (k == 0) mem_rsp_valid = 1'b0;
            else ack(prev_if, 32'hA000_0000 + 32'(k));
            exp_if = ((k % 5) == 4);
            settle();
            check("cont_if_ready", if_req_ready, exp_if);
            check("cont_d_ready", d_req_ready, !exp_if);
            check("cont_mem_addr", mem_req_addr,
                  exp_if ? 32'h0000_1000 + 32'(4 * k) : 32'h0000_3000 + 32'(4 * k));
            prev_if = exp_if;
        end
        next_cycle();
        if_req_stb = 1'b0;
        d_req_stb  = 1'b0;
        ack(prev_if, 32'hA000_000F);
        settle();
        check("cont_end_no_grant", mem_req_stb, 0);
`ifdef ARB_PERF_CNT_EN
        check("cont_perf", perf_conflicts, 32'd15);
`else
        check("cont_perf", perf_conflicts, 32'd0);
`endif
        next_cycle();
        idle_inputs();
        settle();
        next_cycle();
        settle();
        check("cont_if_pulses", if_pulses, 3);
        check("cont_d_pulses", d_pulses, 12);

        // Timeout: 64 silent wait cycles abandon the load; a late ack is flagged as stray.
        pulse_reset();
        d_req_stb  = 1'b1;
        d_req_addr = 32'h0000_3000;
        settle();
        check("tmo_grant", d_req_ready, 1);
        for (int i = 1; i <= 63; i++) begin
            next_cycle();
            d_req_stb = 1'b0;
        end
        next_cycle();
        d_req_stb = 1'b1;
        settle();
        check("tmo_last_wait_ready", d_req_ready, 0);
        check("tmo_last_wait_err", err_flags, 2'b00);
        next_cycle();
        d_req_stb = 1'b0;
        settle();
        check("tmo_err", err_flags, 2'b10);
        next_cycle();
        stray_ack(32'hBAD0_0001);
        settle();
        next_cycle();
        idle_inputs();
        settle();
        check("tmo_late_err", err_flags, 2'b11);

        // Reset in WAIT_IF; the ack after release is stray and delivers nothing.
        next_cycle();
        if_req_stb  = 1'b1;
        if_req_addr = 32'h0000_0400;
        settle();
        check("rmid_grant", if_req_ready, 1);
        next_cycle();
        i_reset_n = 1'b0;
        d_req_stb = 1'b1;
        settle();
        check("rmid_if_ready", if_req_ready, 0);
        check("rmid_d_ready", d_req_ready, 0);
        check("rmid_mem_stb", mem_req_stb, 0);
        next_cycle();
        i_reset_n = 1'b1;
        idle_inputs();
        stray_ack(32'hBAD0_0002);
        settle();
        check("rmid_err_cleared", err_flags, 2'b00);
        check("rmid_perf_cleared", perf_conflicts, 32'h0);
        next_cycle();
        idle_inputs();
        settle();
        check("rmid_err_stray", err_flags, 2'b01);
        check("rmid_if_rsp", if_rsp_valid, 0);
        check("rmid_d_rsp", d_rsp_valid, 0);
        next_cycle();
        settle();
        check("final_if_q_empty", if_q.size(), 0);
        check("final_d_q_empty", d_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
